cap_scan_ctrl: RTL
==================

CAP_SCAN_CTRL -- requirements
Module: cap_scan_ctrl

Interface
REQ-001 Parameter NPADS, default 4: number of capacitive pads scanned, 2..16.
REQ-002 Parameter CW, default 16: width of the charge-time counter and the threshold.
REQ-003 Parameter DISCHARGE_CYCLES, default 64: number of cycles all pads are driven low before each pad measurement.
REQ-004 Parameter TIMEOUT, default 2**CW-1: charge count at which a measurement is forced to end.
REQ-005 Ports, one per line, as follows:
- clock, input, 1: single clock; all state changes on its rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- enable, input, 1: scanning requested.
- threshold, input, CW: touch threshold.
- pad_in, input, NPADS: raw pad levels, asynchronous to clock.
- pad_oe, output, NPADS: 1 means drive the pad low (discharge); 0 means release the pad.
- count_out, output, CW: last measured charge count.
- count_pad, output, clog2(NPADS): pad index of count_out.
- count_valid, output, 1: one-cycle strobe when count_out and count_pad are updated.
- touched, output, NPADS: per-pad touch flags from the last completed scan.
- scan_done, output, 1: one-cycle strobe when touched is updated.

Function
REQ-006 pad_in SHALL pass through a 2-flop synchronizer; only the synchronized value (syn) is used.
REQ-007 States SHALL be IDLE, DISCHARGE, CHARGE and RECORD.
REQ-008 IDLE behaviour:
- pad_oe all ones.
- enable=1 goes to DISCHARGE with idx=0.
- threshold is latched into thr_q at that transition.
REQ-009 DISCHARGE behaviour:
- pad_oe all ones for exactly DISCHARGE_CYCLES cycles.
- Then go to CHARGE with the counter cleared to 0.
REQ-010 CHARGE behaviour:
- pad_oe[idx]=0; all other pad_oe bits stay 1.
- The counter increments in each cycle where syn[idx]=0.
- Go to RECORD in the first cycle where syn[idx]=1 or counter==TIMEOUT; the counter is not incremented in that cycle.
REQ-011 Count meaning: if pad_in[idx] rises D cycles after pad_oe[idx] falls, the recorded count SHALL be D+2, saturating at TIMEOUT.
REQ-012 RECORD behaviour (one cycle):
- pad_oe all ones.
- count_out<=counter, count_pad<=idx, count_valid=1 for the next cycle only.
- shadow[idx]<=(counter>=thr_q).
REQ-013 Exit from RECORD when idx<NPADS-1: set idx<=idx+1 and go to DISCHARGE.
REQ-014 Exit from RECORD when idx==NPADS-1:
- touched<=shadow including the current bit; scan_done=1 for one cycle, coincident with the final count_valid.
- If enable=1: go to DISCHARGE, set idx=0 and re-latch thr_q.
- Otherwise go to IDLE.
REQ-015 enable SHALL be sampled only in IDLE and at scan end; deasserting it mid-scan completes the current scan.
REQ-016 A timeout measurement (counter==TIMEOUT) SHALL be treated as touched whenever TIMEOUT>=thr_q.
REQ-017 threshold=0 SHALL mark every pad touched; the comparison is unsigned at CW bits.
REQ-018 touched SHALL change only at scan_done; partial scans never update it.

Reset
REQ-019 While resetn=0, asynchronously:
- state=IDLE; pad_oe all ones.
- count_out=0, count_pad=0, count_valid=0.
- touched=0, shadow=0, scan_done=0.
- Synchronizer flops, idx, counter and thr_q all 0.
REQ-020 Deasserting resetn mid-scan SHALL abandon the scan; the first scan after reset starts from pad 0 with a fresh DISCHARGE.

Verification
(All scenarios use NPADS=4, CW=8, DISCHARGE_CYCLES=8, TIMEOUT=255; the pad model raises pad_in[i] D_i cycles after pad_oe[i] falls.)
REQ-021 Basic scan: threshold=20, D={10,30,5,40}, enable pulsed one cycle.
- count_valid four times with counts 12,32,7,42 for pads 0..3.
- scan_done once; touched=4'b1010; return to IDLE.
REQ-022 Timeout: pad 2 never rises, threshold=100.
- Pad 2 count_out=255 after 255 CHARGE cycles.
- touched[2]=1; the scan still completes.
REQ-023 Continuous scanning: enable held high.
- Back-to-back scans with DISCHARGE following the final RECORD directly.
- Changing threshold mid-scan affects only the next scan.
REQ-024 Boundary: threshold=0 gives touched=4'b1111; threshold=255 with all D=10 gives touched=4'b0000.
REQ-025 Reset mid-CHARGE on pad 2:
- Outputs at reset values immediately, with pad_oe=4'b1111.
- After release and enable, the first count_valid reports pad 0.
REQ-026 Pad-drive check:
- At most one pad_oe bit is 0 at any time.
- pad_oe is all ones in every DISCHARGE and RECORD cycle.

Source files
------------

// File: rtl/cap_scan_ctrl.sv
// Capacitive touch-pad scanner: discharges all pads, releases one at a time and
// times how long it takes to charge past the input threshold.
module cap_scan_ctrl #(
    parameter int NPADS            = 4,
    parameter int CW               = 16,
    parameter int DISCHARGE_CYCLES = 64,
    parameter int TIMEOUT          = 2**CW - 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [CW-1:0]            threshold,
    input  logic [NPADS-1:0]         pad_in,
    output logic [NPADS-1:0]         pad_oe,
    output logic [CW-1:0]            count_out,
    output logic [$clog2(NPADS)-1:0] count_pad,
    output logic                     count_valid,
    output logic [NPADS-1:0]         touched,
    output logic                     scan_done
);

    localparam int IW = $clog2(NPADS);
    localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_PAD = IW'(NPADS - 1);
    localparam logic [DW-1:0] DIS_LAST = DW'(DISCHARGE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, RECORD} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [NPADS-1:0] r_sync1;
    logic [NPADS-1:0] r_sync2;
    logic [NPADS-1:0] r_shadow;
    logic [NPADS-1:0] w_shadow_upd;
    logic [NPADS-1:0] r_touched;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_count_pad;
    logic [CW-1:0]    r_counter;
    logic [CW-1:0]    r_thr_q;
    logic [CW-1:0]    r_count_out;
    logic [DW-1:0]    r_dis_cnt;
    logic             r_count_valid;
    logic             r_scan_done;
    logic             w_dis_done;
    logic             w_hit;
    logic             w_last;
    logic             w_ge;

    assign w_dis_done = (r_dis_cnt == DIS_LAST);
    assign w_hit      = r_sync2[r_idx] | (r_counter == CNT_MAX);
    assign w_last     = (r_idx == LAST_PAD);
    assign w_ge       = (r_counter >= r_thr_q);

    assign count_out   = r_count_out;
    assign count_pad   = r_count_pad;
    assign count_valid = r_count_valid;
    assign touched     = r_touched;
    assign scan_done   = r_scan_done;

    // Only the pad under measurement is ever released, and only while charging.
    genvar gi;
    generate
        for (gi = 0; gi < NPADS; gi++) begin : g_oe
            assign pad_oe[gi] = ~((r_state == CHARGE) && (r_idx == IW'(gi)));
        end
    endgenerate

    always_comb begin
        w_shadow_upd        = r_shadow;
        w_shadow_upd[r_idx] = w_ge;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (enable) w_state_next = DISCHARGE;
            DISCHARGE: if (w_dis_done) w_state_next = CHARGE;
            CHARGE:    if (w_hit) w_state_next = RECORD;
            RECORD: begin
                if (!w_last || enable) w_state_next = DISCHARGE;
                else                   w_state_next = IDLE;
            end
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_shadow      <= '0;
            r_touched     <= '0;
            r_idx         <= '0;
            r_count_pad   <= '0;
            r_counter     <= '0;
            r_thr_q       <= '0;
            r_count_out   <= '0;
            r_dis_cnt     <= '0;
            r_count_valid <= 1'b0;
            r_scan_done   <= 1'b0;
        end else begin
            r_sync1       <= pad_in;
            r_sync2       <= r_sync1;
            r_count_valid <= 1'b0;
            r_scan_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_dis_cnt <= '0;
                    if (enable) begin
                        r_idx   <= '0;
                        r_thr_q <= threshold;
                    end
                end
                DISCHARGE: begin
                    if (w_dis_done) begin
                        r_dis_cnt <= '0;
                        r_counter <= '0;
                    end else begin
                        r_dis_cnt <= r_dis_cnt + 1'b1;
                    end
                end
                CHARGE: begin
                    if (!w_hit) r_counter <= r_counter + 1'b1;
                end
                RECORD: begin
                    r_dis_cnt     <= '0;
                    r_count_out   <= r_counter;
                    r_count_pad   <= r_idx;
                    r_count_valid <= 1'b1;
                    r_shadow      <= w_shadow_upd;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end else begin
                        // Final pad: publish the whole scan, including this pad's bit.
                        r_touched   <= w_shadow_upd;
                        r_scan_done <= 1'b1;
                        if (enable) begin
                            r_idx   <= '0;
                            r_thr_q <= threshold;
                        end
                    end
                end
                default: r_dis_cnt <= '0;
            endcase
        end
    end

endmodule
